// File: rtl/bcd_serial_comparator_pkg.sv
// Shared types and constants for the digit-serial BCD magnitude comparator.
// Imported by the interface, the digit checker and the comparator top.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_GT,
        CMP_LT
    } cmp_result_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } bcdcmp_state_t;

endpackage

// File: rtl/bcd_serial_comparator_if.sv
// Start/Done request bus between the requester (master) and the comparator (slave).
// Carries both packed-BCD operands and the held Gt/Eq/Lt/Invalid result.
interface bcd_serial_comparator_if
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                              start;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] a;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] b;
    logic                              busy;
    logic                              done;
    logic                              gt;
    logic                              eq;
    logic                              lt;
    logic                              invalid;

    modport master (
        output start, a, b,
        input  busy, done, gt, eq, lt, invalid
    );

    modport slave (
        input  start, a, b,
        output busy, done, gt, eq, lt, invalid
    );

endinterface

// File: rtl/bcd_serial_comparator_digit_valid.sv
// Combinational range check of one BCD digit against a programmable upper limit.
// Used on the top nibble of each operand shift register.
module bcd_digit_valid
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    input  logic [BCD_DIGIT_W-1:0] limit,
    output logic                   ok
);

    assign ok = (digit <= limit);

endmodule

// File: rtl/bcd_serial_comparator.sv
// Digit-serial MSD-first magnitude comparator for packed BCD operands.
// Optional saturating invalid-result counter on err_count when BCDCMP_ERRCNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last comparison
// SCAN  | one digit of each operand checked and compared per clock
// DONE  | one-cycle result-valid pulse on done
module bcd_serial_comparator
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_LIMIT = BCD_MAX,
    parameter int ERRCNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    bcd_serial_comparator_if.slave     bus
`ifdef BCDCMP_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]        err_count
`endif
);

    localparam int OP_W  = BCD_DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [BCD_DIGIT_W-1:0] LIMIT = BCD_DIGIT_W'(DIGIT_LIMIT);

    if (NUM_DIGITS < 1) begin : g_bad_num_digits
        $error("NUM_DIGITS must be at least 1");
    end
    if (ERRCNT_W < 1) begin : g_bad_errcnt_w
        $error("ERRCNT_W must be at least 1");
    end

    bcdcmp_state_t           state;
    logic [OP_W-1:0]         sh_a;
    logic [OP_W-1:0]         sh_b;
    logic [CNT_W-1:0]        digit_cnt;
    logic                    decided;
    cmp_result_t             cmp;
    logic                    inv_sticky;
    logic                    busy_q;
    logic                    done_q;
    logic                    gt_q;
    logic                    eq_q;
    logic                    lt_q;
    logic                    invalid_q;

    logic [BCD_DIGIT_W-1:0]  digit_a;
    logic [BCD_DIGIT_W-1:0]  digit_b;
    logic                    ok_a;
    logic                    ok_b;
    logic                    last_digit;
    logic                    next_decided;
    cmp_result_t             next_cmp;
    logic                    next_invalid;

    assign digit_a    = sh_a[OP_W-1 -: BCD_DIGIT_W];
    assign digit_b    = sh_b[OP_W-1 -: BCD_DIGIT_W];
    assign last_digit = (digit_cnt == CNT_W'(1));

    bcd_digit_valid u_valid_a (.digit(digit_a), .limit(LIMIT), .ok(ok_a));
    bcd_digit_valid u_valid_b (.digit(digit_b), .limit(LIMIT), .ok(ok_b));

    // First differing digit wins; every digit still feeds the validity check.
    always_comb begin
        next_decided = decided;
        next_cmp     = cmp;
        next_invalid = inv_sticky | ~ok_a | ~ok_b;
        if (!decided && (digit_a != digit_b)) begin
            next_decided = 1'b1;
            next_cmp     = (digit_a > digit_b) ? CMP_GT : CMP_LT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sh_a       <= '0;
            sh_b       <= '0;
            digit_cnt  <= '0;
            decided    <= 1'b0;
            cmp        <= CMP_EQ;
            inv_sticky <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_a       <= bus.a;
                        sh_b       <= bus.b;
                        digit_cnt  <= CNT_W'(NUM_DIGITS);
                        decided    <= 1'b0;
                        cmp        <= CMP_EQ;
                        inv_sticky <= 1'b0;
                        gt_q       <= 1'b0;
                        eq_q       <= 1'b0;
                        lt_q       <= 1'b0;
                        invalid_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    sh_a       <= sh_a << BCD_DIGIT_W;
                    sh_b       <= sh_b << BCD_DIGIT_W;
                    digit_cnt  <= digit_cnt - CNT_W'(1);
                    decided    <= next_decided;
                    cmp        <= next_cmp;
                    inv_sticky <= next_invalid;
                    if (last_digit) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        invalid_q <= next_invalid;
                        gt_q      <= !next_invalid && (next_cmp == CMP_GT);
                        eq_q      <= !next_invalid && (next_cmp == CMP_EQ);
                        lt_q      <= !next_invalid && (next_cmp == CMP_LT);
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.gt      = gt_q;
    assign bus.eq      = eq_q;
    assign bus.lt      = lt_q;
    assign bus.invalid = invalid_q;

`ifdef BCDCMP_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if ((state == DONE) && invalid_q && (err_count != {ERRCNT_W{1'b1}})) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_serial_comparator.sv
// Self-checking bench for bcd_serial_comparator: decimal-value reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_bcd_serial_comparator;
    import bcd_pkg::*;

    localparam int N        = 4;
    localparam int W        = 4 * N;
    localparam int LIMIT    = 9;
    localparam int ERRCNT_W = 2;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 0;

    bcd_serial_comparator_if #(.NUM_DIGITS(N)) cmp_if ();

`ifdef BCDCMP_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count;
`endif

    bcd_serial_comparator #(
        .NUM_DIGITS (N),
        .DIGIT_LIMIT(LIMIT),
        .ERRCNT_W   (ERRCNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (cmp_if)
`ifdef BCDCMP_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: operands as decimal numbers; any digit above LIMIT poisons the result.
    function automatic logic [3:0] model_eval(input logic [W-1:0] va, input logic [W-1:0] vb);
        int  da, db, na, nb;
        bit  inv;
        na  = 0;
        nb  = 0;
        inv = 0;
        for (int i = N - 1; i >= 0; i--) begin
            da = int'(va[i*4 +: 4]);
            db = int'(vb[i*4 +: 4]);
            if (da > LIMIT || db > LIMIT) inv = 1;
            na = na * 10 + da;
            nb = nb * 10 + db;
        end
        if (inv) return 4'b0001;
        if (na > nb) return 4'b1000;
        if (na == nb) return 4'b0100;
        return 4'b0010;
    endfunction

    // Timeline model: accepted start keeps busy for N+1 cycles, result in the last one.
    int                  m_left;
    logic [3:0]          m_pend;
    logic [3:0]          m_res;
    logic                m_done;
    logic [ERRCNT_W-1:0] m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_pend <= 4'b0;
            m_res  <= 4'b0;
            m_done <= 1'b0;
            m_err  <= '0;
        end else if (m_left == 0) begin
            m_done <= 1'b0;
            if (cmp_if.start) begin
                m_left <= N + 1;
                m_pend <= model_eval(cmp_if.a, cmp_if.b);
                m_res  <= 4'b0;
            end
        end else begin
            m_left <= m_left - 1;
            m_done <= (m_left == 2);
            if (m_left == 2) m_res <= m_pend;
            if (m_left == 1 && m_res[0] && m_err != {ERRCNT_W{1'b1}}) m_err <= m_err + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("cyc_busy", 32'(cmp_if.busy), 32'(m_left != 0));
            check("cyc_done", 32'(cmp_if.done), 32'(m_done));
            check("cyc_flags", 32'({cmp_if.gt, cmp_if.eq, cmp_if.lt, cmp_if.invalid}), 32'(m_res));
`ifdef BCDCMP_ERRCNT_EN
            check("cyc_errcnt", 32'(err_count), 32'(m_err));
`endif
        end
    end

    task automatic run_cmp(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [3:0] exp, input bit restart);
        int lat;
        int extra;
        @(negedge clk);
        cmp_if.start = 1'b1;
        cmp_if.a     = va;
        cmp_if.b     = vb;
        @(negedge clk);
        cmp_if.start = 1'b0;
        cmp_if.a     = W'($urandom);
        cmp_if.b     = W'($urandom);
        lat = 1;
        while (!cmp_if.done && lat < 20) begin
            @(negedge clk);
            lat++;
            cmp_if.start = (restart && lat == 2);
        end
        cmp_if.start = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'd5);
        check({name, "_flags"}, 32'({cmp_if.gt, cmp_if.eq, cmp_if.lt, cmp_if.invalid}), 32'(exp));
        extra = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (cmp_if.done) extra++;
        end
        check({name, "_extra_done"}, 32'(extra), 32'd0);
        check({name, "_held"}, 32'({cmp_if.gt, cmp_if.eq, cmp_if.lt, cmp_if.invalid}), 32'(exp));
    endtask

    initial begin
        rst          = 1'b1;
        cmp_if.start = 1'b0;
        cmp_if.a     = '0;
        cmp_if.b     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'({cmp_if.busy, cmp_if.done, cmp_if.gt, cmp_if.eq, cmp_if.lt, cmp_if.invalid}), 32'd0);
`ifdef BCDCMP_ERRCNT_EN
        check("reset_errcnt", 32'(err_count), 32'd0);
`endif
        check("model_pin_eq", 32'(model_eval(16'h1234, 16'h1234)), 32'b0100);
        check("model_pin_gt", 32'(model_eval(16'h5000, 16'h4999)), 32'b1000);
        check("model_pin_lt", 32'(model_eval(16'h0009, 16'h0010)), 32'b0010);
        check("model_pin_inv", 32'(model_eval(16'h12A4, 16'h0000)), 32'b0001);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_cmp("eq_1234", 16'h1234, 16'h1234, 4'b0100, 0);
        run_cmp("gt_msd", 16'h5000, 16'h4999, 4'b1000, 0);
        run_cmp("lt_0009", 16'h0009, 16'h0010, 4'b0010, 0);
        run_cmp("eq_9999", 16'h9999, 16'h9999, 4'b0100, 0);
        run_cmp("lt_lsd", 16'h0000, 16'h0001, 4'b0010, 0);
        run_cmp("inv_12a4", 16'h12A4, 16'h0000, 4'b0001, 0);
`ifdef BCDCMP_ERRCNT_EN
        check("errcnt_after_inv", 32'(err_count), 32'd1);
`endif
        run_cmp("inv_after_decide", 16'h5000, 16'h400B, 4'b0001, 0);
        run_cmp("inv_last_digit", 16'h1239, 16'h123F, 4'b0001, 0);
        run_cmp("ignored_restart", 16'h0042, 16'h0041, 4'b1000, 1);

        // Reset in the middle of a scan abandons the operation.
        @(negedge clk);
        cmp_if.start = 1'b1;
        cmp_if.a     = 16'h7777;
        cmp_if.b     = 16'h1111;
        @(negedge clk);
        cmp_if.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_scan", 32'({cmp_if.busy, cmp_if.done, cmp_if.gt, cmp_if.eq, cmp_if.lt, cmp_if.invalid}), 32'd0);
`ifdef BCDCMP_ERRCNT_EN
        check("rst_mid_errcnt", 32'(err_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run_cmp("after_reset", 16'h2024, 16'h2025, 4'b0010, 0);

`ifdef BCDCMP_ERRCNT_EN
        for (int i = 0; i < 5; i++) begin
            run_cmp("sat_inv", 16'hF000, 16'h0000, 4'b0001, 0);
        end
        check("errcnt_saturated", 32'(err_count), 32'd3);
        run_cmp("sat_valid", 16'h0100, 16'h0100, 4'b0100, 0);
        check("errcnt_held", 32'(err_count), 32'd3);
`endif

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
